// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//   Shares one character-LCD controller between two command producers.
//   After reset it plays the HD44780 power-up sequence, then grants 9-bit
//   commands (RS + byte) round-robin, runs the controller start/done
//   handshake and inserts a settle delay after every completed command.
//
// Ports
//   iCLK, iRST           clock, synchronous active-high reset
//   iREQ0/iCMD0/oACK0    requester 0: valid, {RS,data}, one-cycle capture ack
//   iREQ1/iCMD1/oACK1    requester 1: same roles
//   oLCD_DATA/oLCD_RS    byte and RS presented to the LCD controller
//   oLCD_START           start request, held until iLCD_DONE is seen
//   iLCD_DONE            controller completion flag
//   oREADY               power-up sequence finished (sticky until reset)
//   oBUSY                low only while idle in arbitration
module lcd_write_arbiter #(
  parameter int unsigned DLY_CYCLES = 262142,
  parameter int unsigned DLY_W      = 18
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ0,
  input  logic [8:0] iCMD0,
  output logic       oACK0,
  input  logic       iREQ1,
  input  logic [8:0] iCMD1,
  output logic       oACK1,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  input  logic       iLCD_DONE,
  output logic       oREADY,
  output logic       oBUSY
);

  localparam int unsigned CMD_W     = 9;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned INIT_LAST = 4;

  typedef enum logic [1:0] {
    ST_INIT_ISSUE = 2'd0,
    ST_WAIT_DONE  = 2'd1,
    ST_DELAY      = 2'd2,
    ST_ARB        = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         lcd_data_q, lcd_data_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic               lcd_start_q, lcd_start_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;

  logic               dly_last_c;
  logic               any_req_c;
  logic               grant_c;
  logic [CMD_W-1:0]   grant_cmd_c;
  logic [CMD_W-1:0]   rom_c;
  logic               init_more_c;

  // HD44780 power-up commands: function set, display on, clear, entry mode, home
  function automatic logic [CMD_W-1:0] init_rom(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return 9'h038;
      3'd1:    return 9'h00C;
      3'd2:    return 9'h001;
      3'd3:    return 9'h006;
      default: return 9'h080;
    endcase
  endfunction

  // Shared decode used by both the next-state and output logic
  always_comb begin
    dly_last_c  = (cnt_q == DLY_W'(DLY_CYCLES - 1));
    any_req_c   = iREQ0 | iREQ1;
    // On a tie the requester not served last wins; otherwise the lone requester
    grant_c     = (iREQ0 & iREQ1) ? ~last_q : iREQ1;
    grant_cmd_c = grant_c ? iCMD1 : iCMD0;
    rom_c       = init_rom(idx_q);
    init_more_c = (idx_q != IDX_W'(INIT_LAST));
  end

  // State and datapath registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= ST_INIT_ISSUE;
      idx_q       <= '0;
      cnt_q       <= '0;
      lcd_data_q  <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_start_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_start_q <= lcd_start_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_ISSUE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (iLCD_DONE) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (dly_last_c) begin
          // ready_q low means the power-up sequence is still running
          if (!ready_q && init_more_c) state_d = ST_INIT_ISSUE;
          else                         state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (any_req_c) state_d = ST_WAIT_DONE;
      end
      default: state_d = ST_INIT_ISSUE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    lcd_data_d  = lcd_data_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_start_d = lcd_start_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    ready_d     = ready_q;
    last_d      = last_q;
    busy_d      = (state_d != ST_ARB);

    case (state_q)
      ST_INIT_ISSUE: begin
        lcd_rs_d    = rom_c[8];
        lcd_data_d  = rom_c[7:0];
        lcd_start_d = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (iLCD_DONE) begin
          lcd_start_d = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_DELAY: begin
        cnt_d = cnt_q + DLY_W'(1);
        if (dly_last_c && !ready_q) begin
          if (init_more_c) idx_d   = idx_q + IDX_W'(1);
          else             ready_d = 1'b1;
        end
      end
      ST_ARB: begin
        if (any_req_c) begin
          last_d      = grant_c;
          lcd_rs_d    = grant_cmd_c[8];
          lcd_data_d  = grant_cmd_c[7:0];
          lcd_start_d = 1'b1;
          ack0_d      = ~grant_c;
          ack1_d      = grant_c;
        end
      end
      default: ;
    endcase
  end

  assign oLCD_DATA  = lcd_data_q;
  assign oLCD_RS    = lcd_rs_q;
  assign oLCD_START = lcd_start_q;
  assign oACK0      = ack0_q;
  assign oACK1      = ack1_q;
  assign oREADY     = ready_q;
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with a 4-cycle settle delay and a
// controller model that raises done a programmable number of cycles after start.
module tb_lcd_write_arbiter;

  logic       clk;
  logic       iRST;
  logic       iREQ0, iREQ1;
  logic [8:0] iCMD0, iCMD1;
  logic       oACK0, oACK1;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS, oLCD_START;
  logic       lcd_done;
  logic       oREADY, oBUSY;

  lcd_write_arbiter #(.DLY_CYCLES(4), .DLY_W(18)) dut (
    .iCLK(clk), .iRST(iRST),
    .iREQ0(iREQ0), .iCMD0(iCMD0), .oACK0(oACK0),
    .iREQ1(iREQ1), .iCMD1(iCMD1), .oACK1(oACK1),
    .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_START(oLCD_START),
    .iLCD_DONE(lcd_done), .oREADY(oREADY), .oBUSY(oBUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_n = 0;
  int chk_n  = 0;

  int         done_lat = 3;
  int         sc = 0;
  int         cyc = 0;
  logic       prev_start = 1'b0;
  logic [8:0] st_cmd[$];
  int         st_cyc[$];
  logic [10:0] gnt[$];   // {ack1, start, rs, data} captured on each ack
  int         ack0_n = 0, ack1_n = 0, early_n = 0;

  logic [8:0] exp_rom [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};

  // Controller model and output monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (oLCD_START && !prev_start) begin
      st_cmd.push_back({oLCD_RS, oLCD_DATA});
      st_cyc.push_back(cyc);
    end
    prev_start = oLCD_START;
    if (oACK0 || oACK1) begin
      gnt.push_back({oACK1, oLCD_START, oLCD_RS, oLCD_DATA});
      if (!oREADY) early_n++;
    end
    if (oACK0) ack0_n++;
    if (oACK1) ack1_n++;
    if (oLCD_START && !lcd_done) begin
      if (sc == done_lat - 1) begin
        lcd_done = 1'b1;
        sc = 0;
      end else begin
        sc++;
      end
    end else begin
      lcd_done = 1'b0;
      sc = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic cond(input int w, input int tgt);
    case (w)
      0:       return oREADY;
      1:       return oACK0;
      2:       return oACK1;
      3:       return !oBUSY;
      default: return gnt.size() >= tgt;
    endcase
  endfunction

  task automatic wait_cond(input int w, input int tgt, input int lim, input string tag);
    int n = 0;
    while (!cond(w, tgt) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(cond(w, tgt)), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"},  32'(oLCD_DATA),  32'h0);
    chk({tag, "_rs"},    32'(oLCD_RS),    32'h0);
    chk({tag, "_start"}, 32'(oLCD_START), 32'h0);
    chk({tag, "_ack0"},  32'(oACK0),      32'h0);
    chk({tag, "_ack1"},  32'(oACK1),      32'h0);
    chk({tag, "_ready"}, 32'(oREADY),     32'h0);
    chk({tag, "_busy"},  32'(oBUSY),      32'h1);
  endtask

  initial begin
    int b, g, s, a0, a1, e, bad;
    logic [10:0] ge;
    iRST = 1'b1; iREQ0 = 1'b0; iREQ1 = 1'b0; iCMD0 = '0; iCMD1 = '0;
    lcd_done = 1'b0;

    // Reset values, then power-up sequence with no requests
    repeat (3) @(negedge clk);
    chk_reset("rst");
    iRST = 1'b0;
    b = st_cmd.size();
    @(negedge clk);
    chk("init_start", 32'(oLCD_START), 32'd1);
    chk("init_data",  32'(oLCD_DATA),  32'h38);
    wait_cond(0, 0, 200, "init_ready");
    chk("ready_busy", 32'(oBUSY), 32'd0);
    chk("init_count", 32'(st_cmd.size() - b), 32'd5);
    for (int i = 0; i < 5; i++) chk("init_cmd", 32'(st_cmd[b+i]), 32'(exp_rom[i]));
    // start, 3-cycle done, 4 settle cycles, issue: 8 cycles start to start
    for (int i = 1; i < 5; i++) chk("init_gap", 32'(st_cyc[b+i] - st_cyc[b+i-1]), 32'd8);

    // Both requesting continuously: first tie goes to 0, then alternate
    g = gnt.size(); s = st_cmd.size();
    iREQ0 = 1'b1; iREQ1 = 1'b1; iCMD0 = 9'h130; iCMD1 = 9'h131;
    wait_cond(4, g + 4, 400, "rr_grants");
    iREQ0 = 1'b0; iREQ1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ge = gnt[g+i];
      chk("rr_id",    32'(ge[10]),  32'(i % 2));
      chk("rr_start", 32'(ge[9]),   32'd1);
      chk("rr_cmd",   32'(ge[8:0]), (i % 2 == 1) ? 32'h131 : 32'h130);
    end
    wait_cond(3, 0, 50, "rr_idle");
    for (int i = 0; i < 4; i++) chk("rr_bytes", 32'(st_cmd[s+i]), (i % 2 == 1) ? 32'h131 : 32'h130);

    // Lone requester 1 after a requester-1 grant: granted again, 1-cycle latency
    iREQ1 = 1'b1; iCMD1 = 9'h1AA;
    @(negedge clk);
    chk("lone_ack1",  32'(oACK1), 32'd1);
    chk("lone_cmd",   32'({oLCD_RS, oLCD_DATA}), 32'h1AA);
    chk("lone_start", 32'(oLCD_START), 32'd1);
    iREQ1 = 1'b0;
    @(negedge clk);
    chk("lone_pulse", 32'(oACK1), 32'd0);
    wait_cond(3, 0, 50, "lone_idle");

    // Slow controller: start and data held for 100 cycles, other side waits
    done_lat = 100;
    a1 = ack1_n;
    iREQ0 = 1'b1; iCMD0 = 9'h055;
    wait_cond(1, 0, 5, "slow_ack0");
    iREQ0 = 1'b0; iREQ1 = 1'b1; iCMD1 = 9'h1BB;
    bad = 0;
    repeat (99) begin
      @(negedge clk);
      if (!(oLCD_START === 1'b1 && {oLCD_RS, oLCD_DATA} === 9'h055 && oACK1 === 1'b0)) bad++;
    end
    chk("slow_hold",  32'(bad), 32'd0);
    chk("slow_noack", 32'(ack1_n - a1), 32'd0);
    @(negedge clk);
    chk("slow_clear", 32'(oLCD_START), 32'd0);
    done_lat = 3;
    wait_cond(2, 0, 30, "slow_ack1");
    chk("slow_cmd1", 32'({oLCD_RS, oLCD_DATA}), 32'h1BB);
    iREQ1 = 1'b0;

    // Reset while the requester-1 command waits for done
    a0 = ack0_n; a1 = ack1_n;
    iRST = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst");
    iRST = 1'b0;
    iREQ0 = 1'b1; iCMD0 = 9'h141;
    e = early_n;
    @(negedge clk);
    chk("re_start", 32'(oLCD_START), 32'd1);
    chk("re_data",  32'(oLCD_DATA),  32'h38);
    wait_cond(0, 0, 200, "re_ready");
    chk("re_noack1", 32'(ack1_n - a1), 32'd0);
    chk("re_noack0", 32'(ack0_n - a0), 32'd0);

    // Request held through init is served only after ready
    wait_cond(1, 0, 5, "init_req_ack");
    chk("irq_cmd",   32'({oLCD_RS, oLCD_DATA}), 32'h141);
    chk("irq_start", 32'(oLCD_START), 32'd1);
    chk("irq_early", 32'(early_n - e), 32'd0);
    iREQ0 = 1'b0;
    wait_cond(3, 0, 50, "irq_idle");
    chk("irq_once",  32'(ack0_n - a0), 32'd1);
    chk("irq_none1", 32'(ack1_n - a1), 32'd0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
